uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-level framing stage placed directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and data, hunts for a start-of-frame byte, collects a length-prefixed payload into an internal buffer, and verifies an 8-bit additive checksum. Validated frames are held for a consumer that reads the payload by address and acknowledges it. Malformed, oversize and dropped traffic is reported by one-cycle error pulses.

## Interface
- SOF, 8'hA5: start-of-frame byte value.
- MAX_LEN, 16: maximum payload bytes (1..255); buffer depth.
- TIMEOUT_CYCLES, 50_000: inter-byte timeout in clk cycles (used only with the timeout feature).
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rx_done  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- frame_valid  out  1  complete, checksum-good frame is held; reset 0.
- frame_ack  in  1  consumer releases the held frame; ignored unless frame_valid.
- frame_len  out  8  payload length of held frame; reset 0.
- rd_addr  in  $clog2(MAX_LEN)  payload read address.
- rd_data  out  8  payload byte at rd_addr, registered; reset 0.
- crc_err  out  1  one-cycle pulse: checksum mismatch; reset 0.
- overflow_err  out  1  one-cycle pulse: LEN > MAX_LEN, or byte dropped while holding; reset 0.
- timeout_err  out  1  one-cycle pulse: inter-byte timeout; reset 0.

## Operation
- Frame on the wire: SOF, LEN, LEN payload bytes, CSUM. Good frame: (LEN + sum of payload + CSUM) mod 256 == 0.
- All actions occur only on cycles with rx_done=1. Exceptions: frame_ack, timeout and reset.
- States: IDLE, LEN, PAYLOAD, CSUM, HOLD.
- IDLE: byte == SOF -> LEN. Any other byte is discarded silently.
- LEN: byte > MAX_LEN -> overflow_err, IDLE. Byte == 0 -> CSUM. Otherwise -> PAYLOAD. In all cases the 8-bit running sum and the length register are loaded with the byte, and the write index is cleared.
- PAYLOAD: write the byte to buffer[index], add it to the sum, increment index. When index reaches LEN -> CSUM.
- CSUM: if (sum + byte) mod 256 == 0 -> HOLD, with frame_len = LEN. Otherwise -> crc_err, IDLE.
- HOLD: frame_valid=1. Buffer contents and frame_len stay frozen.
  - rx_done without frame_ack: byte dropped, overflow_err pulse.
  - frame_ack: -> IDLE.
  - rx_done and frame_ack in the same cycle: the byte is evaluated as in IDLE, so SOF goes straight to LEN and no error is raised.
- A new SOF inside LEN, PAYLOAD or CSUM is treated as data; no resynchronisation occurs.
- Sum and index arithmetic is 8-bit modulo; no carry is kept.
- Reset at any point: state IDLE, all outputs 0. Buffer contents are undefined and need no clearing.

## Timing
- frame_valid rises on the cycle after the rx_done that carries CSUM.
- frame_valid falls on the cycle after frame_ack.
- crc_err and overflow_err are registered: they pulse on the cycle after the offending rx_done. timeout_err pulses on the cycle after the expiry.
- rd_data = buffer[rd_addr sampled on the previous edge]; one-cycle read latency, valid in any state. Contents are meaningful only while frame_valid.
- Back-to-back strobes on consecutive cycles are supported; no throughput limit.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - An inter-byte counter clears on every rx_done and counts while in LEN, PAYLOAD or CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done, the block pulses timeout_err and returns to IDLE.
  - The counter is idle in IDLE and HOLD.
- FRAME_TIMEOUT_EN undefined: no counter is built, timeout_err is tied 0, and a partial frame waits indefinitely.

## Structure
- Shared package uart_pkg holds the state encodings (IDLE, LEN, PAYLOAD, CSUM, HOLD as 3-bit localparams) and the default SOF constant.
- Sub-module uart_frame_buf: MAX_LEN x 8 single-write, synchronous-read memory (wr_en, wr_addr, wr_data, rd_addr, rd_data). The FSM, sum, index and error logic stay in the top level.

## Test plan
- A5 03 11 22 33 97 -> frame_valid=1 one cycle after the last strobe; frame_len=3; reading addr 0,1,2 gives 11,22,33 one cycle later. frame_ack -> frame_valid=0 next cycle.
- 00 FF A5 00 00 -> leading bytes ignored; frame_valid with frame_len=0; no error pulses.
- A5 02 01 02 00 -> crc_err pulses once, frame_valid stays 0. A following A5 01 7F 80 -> valid frame, len 1, data 7F.
- MAX_LEN=16: A5 11 -> overflow_err after the LEN byte, state IDLE. A byte 55 sent while a frame is held -> overflow_err, frame_len and data unchanged. A5 strobed in the same cycle as frame_ack -> accepted as SOF.
- FRAME_TIMEOUT_EN defined: A5 02 01 then silence for TIMEOUT_CYCLES -> timeout_err once. A subsequent complete frame is accepted. Without the macro, the same stimulus never pulses timeout_err.
- rst asserted mid-PAYLOAD -> all outputs 0 immediately. After release, A5 01 7F 80 is accepted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART framing stage: FSM state encodings and the
// default start-of-frame byte.
package uart_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // True while a frame is partially received and the inter-byte gap matters.
  function automatic logic is_collecting(input logic [2:0] st);
    return (st == ST_LEN) || (st == ST_PAYLOAD) || (st == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 memory with one write port and a registered read
// port (one-cycle latency, read data resets to 0).
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= 8'd0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Length-prefixed, checksummed frame parser behind a UART receiver.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50_000,
  localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_done,
  input  logic [7:0]    rx_byte,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [7:0]    frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          crc_err,
  output logic          overflow_err,
  output logic          timeout_err
);

  // Handshakes: rx_done is a valid-only strobe with no backpressure; a byte
  // arriving while a frame is held is dropped and flagged. frame_valid stays
  // high until a cycle with frame_ack=1; the frame is released on that cycle.

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [7:0] len_q;
  logic [7:0] sum_q;
  logic [7:0] idx_q;
  logic [7:0] idx_inc;
  logic [7:0] csum_total;
  logic       is_sof;
  logic       len_too_big;
  logic       tmo_hit;
  logic       load_len;
  logic       wr_en;
  logic       accept;
  logic       crc_nx;
  logic       ovf_nx;

  assign idx_inc     = idx_q + 8'd1;
  assign csum_total  = sum_q + rx_byte;
  assign is_sof      = (rx_byte == SOF);
  assign len_too_big = (rx_byte > MAX_LEN_B);
  assign frame_valid = (state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (rx_done && is_sof) state_nx = ST_LEN;
      ST_LEN: begin
        if (rx_done) begin
          if (len_too_big)          state_nx = ST_IDLE;
          else if (rx_byte == 8'd0) state_nx = ST_CSUM;
          else                      state_nx = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (rx_done && idx_inc == len_q) state_nx = ST_CSUM;
      ST_CSUM: if (rx_done) state_nx = (csum_total == 8'd0) ? ST_HOLD : ST_IDLE;
      // An ack releases the frame; a byte in the same cycle is judged as in IDLE.
      ST_HOLD: if (frame_ack) state_nx = (rx_done && is_sof) ? ST_LEN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (tmo_hit) state_nx = ST_IDLE;
  end

  always_comb begin
    load_len = 1'b0;
    wr_en    = 1'b0;
    accept   = 1'b0;
    crc_nx   = 1'b0;
    ovf_nx   = 1'b0;
    case (state)
      ST_LEN: begin
        load_len = rx_done;
        ovf_nx   = rx_done && len_too_big;
      end
      ST_PAYLOAD: wr_en = rx_done;
      ST_CSUM: begin
        accept = rx_done && (csum_total == 8'd0);
        crc_nx = rx_done && (csum_total != 8'd0);
      end
      ST_HOLD: ovf_nx = rx_done && !frame_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= 8'd0;
      sum_q        <= 8'd0;
      idx_q        <= 8'd0;
      frame_len    <= 8'd0;
      crc_err      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      crc_err      <= crc_nx;
      overflow_err <= ovf_nx;
      if (load_len) begin
        len_q <= rx_byte;
        sum_q <= rx_byte;
        idx_q <= 8'd0;
      end else if (wr_en) begin
        sum_q <= csum_total;
        idx_q <= idx_inc;
      end
      if (accept) frame_len <= len_q;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] gap_cnt;
  logic          collecting;

  assign collecting = is_collecting(state);
  assign tmo_hit    = collecting && !rx_done && (gap_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (rx_done || !collecting || tmo_hit) gap_cnt <= '0;
      else                                   gap_cnt <= gap_cnt + CW'(1);
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (rx_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed scenarios plus randomized frames
// checked against a queue-based frame model.
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 40;
  localparam int         AW      = $clog2(MAX_LEN);
  localparam logic [7:0] SOF     = 8'hA5;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_done;
  logic [7:0]    rx_byte;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic          frame_valid;
  logic [7:0]    frame_len;
  logic [7:0]    rd_data;
  logic          crc_err;
  logic          overflow_err;
  logic          timeout_err;

  uart_frame_parser #(
    .SOF            (SOF),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done      (rx_done),
    .rx_byte      (rx_byte),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .crc_err      (crc_err),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_diff = 0;
  int fv_diff = 0;

  // Reference model: a frame is "collected" as a list of bytes after SOF and
  // judged once LEN + 2 bytes have arrived.
  bit         m_in_frame;
  bit         m_held;
  bit         m_crc;
  bit         m_ovf;
  int         m_held_len;
  logic [7:0] m_coll[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  function automatic void model_reset();
    m_in_frame = 0;
    m_held     = 0;
    m_crc      = 0;
    m_ovf      = 0;
    m_held_len = 0;
    m_coll.delete();
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic rxd, input logic [7:0] b, input logic ack);
    int s;
    m_crc = 0;
    m_ovf = 0;
    if (m_held) begin
      if (!ack) begin
        if (rxd) m_ovf = 1;
        return;
      end
      m_held = 0;
    end
    if (!rxd) return;
    if (!m_in_frame) begin
      if (b == SOF) begin
        m_in_frame = 1;
        m_coll.delete();
      end
      return;
    end
    m_coll.push_back(b);
    if (m_coll.size() == 1 && int'(b) > MAX_LEN) begin
      m_ovf = 1;
      m_in_frame = 0;
      return;
    end
    if (m_coll.size() == int'(m_coll[0]) + 2) begin
      m_in_frame = 0;
      s = 0;
      foreach (m_coll[i]) s += int'(m_coll[i]);
      if (s % 256 == 0) begin
        m_held = 1;
        m_held_len = int'(m_coll[0]);
        exp_q.delete();
        for (int i = 1; i <= m_held_len; i++) exp_q.push_back(m_coll[i]);
      end else begin
        m_crc = 1;
      end
    end
  endfunction

  // One clock: drive inputs, let the edge pass, advance the model and record
  // any divergence in error pulses or frame_valid.
  task automatic cycle(input logic rxd, input logic [7:0] b, input logic ack);
    rx_done = rxd;
    rx_byte = b;
    frame_ack = ack;
    @(posedge clk);
    #1;
    model_step(rxd, b, ack);
    if (crc_err !== m_crc || overflow_err !== m_ovf) pulse_diff++;
    if (frame_valid !== m_held) fv_diff++;
    rx_done = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t q, input int max_gap);
    foreach (q[i]) begin
      repeat ($urandom_range(max_gap, 0)) cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b1, q[i], 1'b0);
    end
  endtask

  task automatic read_payload(input int n);
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      cycle(1'b0, 8'h00, 1'b0);
      got_q.push_back(rd_data);
    end
  endtask

  function automatic byte_q_t make_frame(input int len, input bit corrupt);
    byte_q_t f;
    logic [7:0] b;
    int s;
    f.push_back(SOF);
    f.push_back(8'(len));
    s = len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(255, 0));
      f.push_back(b);
      s += int'(b);
    end
    b = 8'((256 - (s % 256)) % 256);
    if (corrupt) b = b ^ 8'(1 << $urandom_range(7, 0));
    f.push_back(b);
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rx_done = 1'b0;
    rx_byte = 8'h00;
    frame_ack = 1'b0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_len !== 8'h00) begin errors++; $display("FAIL reset_frame_len: got %h expected 00", frame_len); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    checks++; if ({crc_err, overflow_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b expected 000", {crc_err, overflow_err, timeout_err}); end
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_basic();
    byte_q_t f;
    logic [7:0] want[3];
    int p0, v0;
    p0 = pulse_diff; v0 = fv_diff;
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    f = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_bytes(f, 0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", frame_valid); end
    cycle(1'b1, 8'h97, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", frame_valid); end
    checks++; if (frame_len !== 8'd3) begin errors++; $display("FAIL basic_len: got %0d expected 3", frame_len); end
    read_payload(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], want[i]); end
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b expected 0", frame_valid); end
    checks++; if (pulse_diff != p0 || fv_diff != v0) begin errors++; $display("FAIL basic_trace: got %0d/%0d diffs expected 0/0", pulse_diff - p0, fv_diff - v0); end
  endtask

  task automatic test_zero_len();
    byte_q_t f;
    int p0;
    p0 = pulse_diff;
    f = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    send_bytes(f, 1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", frame_valid); end
    checks++; if (frame_len !== 8'd0) begin errors++; $display("FAIL zero_len: got %0d expected 0", frame_len); end
    checks++; if (pulse_diff != p0) begin errors++; $display("FAIL zero_pulses: got %0d diffs expected 0", pulse_diff - p0); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_crc();
    byte_q_t f;
    f = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send_bytes(f, 0);
    checks++; if (crc_err !== 1'b1) begin errors++; $display("FAIL crc_pulse: got %b expected 1", crc_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL crc_valid: got %b expected 0", frame_valid); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL crc_single: got %b expected 0", crc_err); end
    f = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_bytes(f, 0);
    checks++; if (frame_valid !== 1'b1 || frame_len !== 8'd1) begin errors++; $display("FAIL crc_recover: got valid %b len %0d expected 1 1", frame_valid, frame_len); end
    read_payload(1);
    checks++; if (got_q[0] !== 8'h7F) begin errors++; $display("FAIL crc_recover_data: got %h expected 7f", got_q[0]); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overflow();
    byte_q_t f;
    int bad;
    f = {8'hA5, 8'h11};
    send_bytes(f, 0);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_len: got %b expected 1", overflow_err); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_single: got %b expected 0", overflow_err); end
    f = make_frame(MAX_LEN, 1'b0);
    send_bytes(f, 1);
    checks++; if (frame_valid !== 1'b1 || frame_len !== 8'(MAX_LEN)) begin errors++; $display("FAIL ovf_maxlen: got valid %b len %0d expected 1 %0d", frame_valid, frame_len, MAX_LEN); end
    cycle(1'b1, 8'h55, 1'b0);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_drop: got %b expected 1", overflow_err); end
    checks++; if (frame_valid !== 1'b1 || frame_len !== 8'(MAX_LEN)) begin errors++; $display("FAIL ovf_frozen: got valid %b len %0d expected 1 %0d", frame_valid, frame_len, MAX_LEN); end
    read_payload(MAX_LEN);
    bad = 0;
    for (int i = 0; i < MAX_LEN; i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_data: got %0d bad bytes expected 0", bad); end
    cycle(1'b1, SOF, 1'b1);
    checks++; if (overflow_err !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL ovf_ack_sof: got err %b valid %b expected 0 0", overflow_err, frame_valid); end
    f = {8'h01, 8'h42, 8'hBD};
    send_bytes(f, 0);
    checks++; if (frame_valid !== 1'b1 || frame_len !== 8'd1) begin errors++; $display("FAIL ovf_ack_frame: got valid %b len %0d expected 1 1", frame_valid, frame_len); end
    read_payload(1);
    checks++; if (got_q[0] !== 8'h42) begin errors++; $display("FAIL ovf_ack_data: got %h expected 42", got_q[0]); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    byte_q_t f;
    int bad;
    f = make_frame(5, 1'b0);
    send_bytes(f, 0);
    f = make_frame(int'($urandom_range(MAX_LEN, 1)), 1'b0);
    cycle(1'b1, f.pop_front(), 1'b1);
    send_bytes(f, 0);
    checks++; if (frame_valid !== 1'b1 || int'(frame_len) != m_held_len) begin errors++; $display("FAIL b2b_frame: got valid %b len %0d expected 1 %0d", frame_valid, frame_len, m_held_len); end
    read_payload(m_held_len);
    bad = 0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data: got %0d bad bytes expected 0", bad); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    byte_q_t f;
    int kind, bad, p0, v0;
    logic [7:0] junk;
    p0 = pulse_diff; v0 = fv_diff;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(2, 0)) begin
        junk = 8'($urandom_range(255, 0));
        if (junk == SOF) junk = 8'h00;
        cycle(1'b1, junk, 1'b0);
      end
      kind = int'($urandom_range(9, 0));
      if (kind == 0) begin
        f = {SOF, 8'($urandom_range(255, MAX_LEN + 1))};
      end else begin
        f = make_frame(int'($urandom_range(MAX_LEN, 0)), kind == 1);
      end
      send_bytes(f, 3);
      checks++; if (frame_valid !== m_held) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, frame_valid, m_held); end
      if (m_held) begin
        repeat ($urandom_range(2, 0)) cycle(1'b1, 8'($urandom_range(255, 0)), 1'b0);
        checks++; if (int'(frame_len) != m_held_len) begin errors++; $display("FAIL rand_len[%0d]: got %0d expected %0d", n, frame_len, m_held_len); end
        read_payload(m_held_len);
        bad = 0;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_data[%0d]: got %0d bad bytes expected 0", n, bad); end
        cycle(1'b0, 8'h00, 1'b1);
      end
    end
    checks++; if (pulse_diff != p0) begin errors++; $display("FAIL rand_pulses: got %0d diffs expected 0", pulse_diff - p0); end
    checks++; if (fv_diff != v0) begin errors++; $display("FAIL rand_valid_trace: got %0d diffs expected 0", fv_diff - v0); end
  endtask

  task automatic test_timeout();
    byte_q_t f;
    int first, seen, p0;
    first = -1; seen = 0;
    f = {8'hA5, 8'h02, 8'h01};
    send_bytes(f, 0);
    p0 = pulse_diff;
    for (int k = 1; k <= TMO + 20; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (timeout_err === 1'b1) begin
        seen++;
        if (first < 0) first = k;
      end
    end
`ifdef FRAME_TIMEOUT_EN
    checks++; if (seen != 1) begin errors++; $display("FAIL tmo_count: got %0d expected 1", seen); end
    checks++; if (first != TMO) begin errors++; $display("FAIL tmo_cycle: got %0d expected %0d", first, TMO); end
    m_in_frame = 0;
`else
    checks++; if (seen != 0) begin errors++; $display("FAIL tmo_absent: got %0d expected 0", seen); end
`endif
    f = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_bytes(f, 0);
    checks++; if (frame_valid !== m_held || pulse_diff != p0) begin errors++; $display("FAIL tmo_after: got valid %b diffs %0d expected %b 0", frame_valid, pulse_diff - p0, m_held); end
    if (m_held) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    byte_q_t f;
    f = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_bytes(f, 0);
    cycle(1'b0, 8'h00, 1'b1);
    rd_addr = '0;
    f = {8'hA5, 8'h02, 8'h01};
    send_bytes(f, 0);
    checks++; if (frame_len !== 8'd3) begin errors++; $display("FAIL rstmid_len_before: got %0d expected 3", frame_len); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (frame_len !== 8'd0 || rd_data !== 8'd0) begin errors++; $display("FAIL rstmid_regs: got len %h data %h expected 00 00", frame_len, rd_data); end
    checks++; if ({frame_valid, crc_err, overflow_err, timeout_err} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {frame_valid, crc_err, overflow_err, timeout_err}); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    f = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_bytes(f, 0);
    checks++; if (frame_valid !== 1'b1 || frame_len !== 8'd1) begin errors++; $display("FAIL rstmid_frame: got valid %b len %0d expected 1 1", frame_valid, frame_len); end
    read_payload(1);
    checks++; if (got_q[0] !== 8'h7F) begin errors++; $display("FAIL rstmid_data: got %h expected 7f", got_q[0]); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_zero_len();
    test_crc();
    test_overflow();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
